// File: rtl/sine_quarter_recon.sv
// Quarter-wave ROM return path: issues folded-address reads, realigns the negate flag with the ROM latency,
// and emits signed full-wave samples through a credit-managed output FIFO. Define SINE_RECON_ZCROSS_EN for o_zcross.
module sine_quarter_recon #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 16,
    parameter int ROM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_neg,
    output logic              o_rom_en,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W:0]   o_sample
`ifdef SINE_RECON_ZCROSS_EN
    ,
    output logic              o_zcross
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = PTR_W + 2;
`ifdef SINE_RECON_ZCROSS_EN
    localparam int ENT_W = DATA_W + 2;
`else
    localparam int ENT_W = DATA_W + 1;
`endif

    // Two's-complement negate of the zero-extended magnitude; wraps 0 back to 0.
    function automatic logic [DATA_W:0] f_recon(input logic [DATA_W-1:0] mag, input logic neg);
        logic [DATA_W:0] ext;
        ext = {1'b0, mag};
        if (neg) begin
            f_recon = ~ext + {{DATA_W{1'b0}}, 1'b1};
        end else begin
            f_recon = ext;
        end
    endfunction

    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic [CRD_W-1:0]    w_credit_used;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [CNT_W-1:0]    w_inflight_nxt;
    logic [PTR_W-1:0]    w_rd_ptr_nxt;
    logic [ENT_W-1:0]    w_push_ent;
    logic [ENT_W-1:0]    w_head_nxt;

    logic                r_rom_en;
    logic                r_rom_neg;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [ROM_LAT-1:0]  r_pipe_vld;
    logic [ROM_LAT-1:0]  r_pipe_neg;
    logic                r_smp_vld;
    logic [DATA_W:0]     r_smp;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_inflight;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [ENT_W-1:0]    r_mem [FIFO_DEPTH];
    logic                r_out_vld;
    logic [ENT_W-1:0]    r_out_ent;

    // Credits cover both FIFO occupancy and reads still in the ROM pipeline, so a push never finds the FIFO full.
    assign w_credit_used = CRD_W'(r_count) + CRD_W'(r_inflight);
    assign o_ready       = (w_credit_used < CRD_W'(FIFO_DEPTH));

    // Handshakes, FIFO next-state and the next registered head entry.
    always_comb begin
        w_accept       = i_valid && o_ready;
        w_push         = r_smp_vld;
        w_pop          = r_out_vld && i_ready;
        w_count_nxt    = r_count;
        w_inflight_nxt = r_inflight;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_head_nxt     = {ENT_W{1'b0}};
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
        case ({w_accept, w_push})
            2'b10:   w_inflight_nxt = r_inflight + CNT_W'(1);
            2'b01:   w_inflight_nxt = r_inflight - CNT_W'(1);
            default: w_inflight_nxt = r_inflight;
        endcase
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
        // The incoming entry becomes the head when it lands in the slot the read pointer moves to.
        if (w_count_nxt == CNT_W'(0)) begin
            w_head_nxt = {ENT_W{1'b0}};
        end else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = w_push_ent;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

`ifdef SINE_RECON_ZCROSS_EN
    logic r_prev_sign;

    // Samples leave in push order, so comparing against the previous pushed sign matches the popped order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_sign <= 1'b0;
        end else if (w_push) begin
            r_prev_sign <= r_smp[DATA_W];
        end else begin
            r_prev_sign <= r_prev_sign;
        end
    end

    assign w_push_ent = {r_smp[DATA_W] ^ r_prev_sign, r_smp};
    assign o_zcross   = r_out_ent[DATA_W+1];
`else
    assign w_push_ent = r_smp;
`endif

    // ROM request register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rom_en   <= 1'b0;
            r_rom_neg  <= 1'b0;
            r_rom_addr <= {ADDR_W{1'b0}};
        end else begin
            r_rom_en  <= w_accept;
            r_rom_neg <= w_accept & i_neg;
            if (w_accept) begin
                r_rom_addr <= i_addr;
            end
        end
    end

    // Valid/neg shift register whose tail lines up with the cycle the ROM data is valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe_vld <= {ROM_LAT{1'b0}};
            r_pipe_neg <= {ROM_LAT{1'b0}};
        end else begin
            r_pipe_vld[0] <= r_rom_en;
            r_pipe_neg[0] <= r_rom_neg;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_neg[i] <= r_pipe_neg[i-1];
            end
        end
    end

    // Reconstructed sample register feeding the FIFO push.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_smp_vld <= 1'b0;
            r_smp     <= {(DATA_W+1){1'b0}};
        end else begin
            r_smp_vld <= r_pipe_vld[ROM_LAT-1];
            if (r_pipe_vld[ROM_LAT-1]) begin
                r_smp <= f_recon(i_rom_data, r_pipe_neg[ROM_LAT-1]);
            end
        end
    end

    // FIFO storage; contents are don't-care until pointed to by a valid count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_ent;
        end
    end

    // FIFO pointers, occupancy, in-flight credits and registered head.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count    <= {CNT_W{1'b0}};
            r_inflight <= {CNT_W{1'b0}};
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_out_vld  <= 1'b0;
            r_out_ent  <= {ENT_W{1'b0}};
        end else begin
            r_count    <= w_count_nxt;
            r_inflight <= w_inflight_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_out_vld <= (w_count_nxt != CNT_W'(0));
            r_out_ent <= w_head_nxt;
        end
    end

    assign o_rom_en   = r_rom_en;
    assign o_rom_addr = r_rom_addr;
    assign o_valid    = r_out_vld;
    assign o_sample   = r_out_ent[DATA_W:0];

endmodule

// File: tb/tb_sine_quarter_recon.sv
// Directed bench for sine_quarter_recon with a behavioural quarter-wave ROM of fixed read latency.
module tb_sine_quarter_recon;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 16;
    localparam int ROM_LAT    = 2;
    localparam int FIFO_DEPTH = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_valid;
    logic              o_ready;
    logic [ADDR_W-1:0] i_addr;
    logic              i_neg;
    logic              o_rom_en;
    logic [ADDR_W-1:0] o_rom_addr;
    logic [DATA_W-1:0] i_rom_data;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W:0]   o_sample;
    logic              w_zc;

    int tests = 0;
    int fails = 0;
    logic [17:0] obs_q[$];
    logic [17:0] last_obs;
    logic [15:0] rom_pipe [ROM_LAT];
    logic [15:0] junk = 16'h0000;

    sine_quarter_recon #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_addr(i_addr), .i_neg(i_neg), .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr),
        .i_rom_data(i_rom_data), .o_valid(o_valid), .i_ready(i_ready), .o_sample(o_sample)
`ifdef SINE_RECON_ZCROSS_EN
        , .o_zcross(w_zc)
`endif
    );
`ifndef SINE_RECON_ZCROSS_EN
    assign w_zc = 1'b0;
`endif

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] lut(input logic [13:0] a);
        case (a)
            14'h1000: lut = 16'h5A5A;
            14'h0001: lut = 16'h0000;
            14'h0002: lut = 16'hFFFF;
            14'h0003: lut = 16'h0005;
            14'h0004: lut = 16'h0003;
            14'h0005: lut = 16'h0002;
            14'h0006: lut = 16'h0007;
            14'h0007: lut = 16'h0000;
            default:  lut = {2'b00, a} ^ 16'hA5C3;
        endcase
    endfunction

    function automatic logic [16:0] exp_smp(input logic [15:0] m, input logic neg);
        logic [17:0] t;
        t = 18'h20000 - {2'b00, m};
        exp_smp = neg ? t[16:0] : {1'b0, m};
    endfunction

    // Behavioural ROM: data valid ROM_LAT cycles after o_rom_en, garbage otherwise.
    always @(posedge i_clk) begin
        junk        <= junk + 16'h1357;
        rom_pipe[0] <= o_rom_en ? lut(o_rom_addr) : junk;
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign i_rom_data = rom_pipe[ROM_LAT-1];

    // Output monitor: logs every sample that will be popped at the coming edge.
    always @(negedge i_clk) begin
        #1;
        if (i_rst_n && o_valid && i_ready) obs_q.push_back({w_zc, o_sample});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_next(input string tag, input logic [16:0] exp);
        int n;
        n = 0;
        while (obs_q.size() == 0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        chk({tag, "_arrived"}, 32'(obs_q.size() != 0), 32'd1);
        if (obs_q.size() != 0) begin
            last_obs = obs_q.pop_front();
            chk(tag, 32'(last_obs[16:0]), 32'(exp));
        end
    endtask

    task automatic send_req(input logic [13:0] a, input logic neg);
        int n;
        n = 0;
        i_addr  = a;
        i_neg   = neg;
        i_valid = 1'b1;
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk("accept_bound", 32'(n < 200), 32'd1);
        @(negedge i_clk);
    endtask

    int acc;
    int n;

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_addr  = 14'h0000;
        i_neg   = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_rom_en", 32'(o_rom_en), 32'd0);
        chk("rst_rom_addr", 32'(o_rom_addr), 32'd0);
        chk("rst_sample", 32'(o_sample), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Single request: exact latency of ROM read and output sample.
        i_addr  = 14'h1000;
        i_neg   = 1'b0;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_addr  = 14'h3FFF;
        i_neg   = 1'b1;
        chk("lat_rom_en", 32'(o_rom_en), 32'd1);
        chk("lat_rom_addr", 32'(o_rom_addr), 32'h1000);
        chk("lat_valid_c0", 32'(o_valid), 32'd0);
        for (int k = 2; k <= ROM_LAT + 3; k++) begin
            @(negedge i_clk);
            chk("lat_valid", 32'(o_valid), 32'(k == ROM_LAT + 3));
        end
        chk("lat_sample", 32'(o_sample), 32'h05A5A);
        repeat (3) @(negedge i_clk);
        obs_q.delete();

        send_req(14'h1000, 1'b1);
        i_valid = 1'b0;
        expect_next("neg_5a5a", 17'h1A5A6);
        send_req(14'h0001, 1'b1);
        i_valid = 1'b0;
        expect_next("neg_zero", 17'h00000);
        send_req(14'h0002, 1'b1);
        i_valid = 1'b0;
        expect_next("neg_ffff", 17'h10001);

        // Backpressure: credits stop acceptance at FIFO_DEPTH.
        i_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            i_addr  = 14'h0010 + 14'(acc);
            i_neg   = acc[0];
            i_valid = 1'b1;
            if (o_ready) acc++;
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        chk("bp_accepts", 32'(acc), 32'(FIFO_DEPTH));
        chk("bp_ready_low", 32'(o_ready), 32'd0);
        chk("bp_valid", 32'(o_valid), 32'd1);
        i_ready = 1'b1;
        for (int j = 0; j < 4; j++) expect_next("bp_drain", exp_smp(lut(14'h0010 + 14'(j)), j[0]));
        repeat (10) @(negedge i_clk);
        chk("bp_no_extra", 32'(obs_q.size()), 32'd0);

        // Streaming with alternating negate.
        for (int j = 0; j < 64; j++) send_req(14'h0100 + 14'(j), j[0]);
        i_valid = 1'b0;
        for (int j = 0; j < 64; j++) expect_next("stream", exp_smp(lut(14'h0100 + 14'(j)), j[0]));
        repeat (10) @(negedge i_clk);
        chk("stream_no_extra", 32'(obs_q.size()), 32'd0);

        // Reset with reads in flight and FIFO entries pending.
        i_ready = 1'b0;
        for (int j = 0; j < 4; j++) send_req(14'h0200 + 14'(j), j[0]);
        i_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        @(negedge i_clk);
        chk("rst_pre_valid", 32'(o_valid), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(o_valid), 32'd0);
        chk("rst_async_sample", 32'(o_sample), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        obs_q.delete();
        repeat (20) @(negedge i_clk);
        chk("rst_no_stale", 32'(obs_q.size()), 32'd0);
        chk("rst_ready_after", 32'(o_ready), 32'd1);

`ifdef SINE_RECON_ZCROSS_EN
        begin
            logic [13:0] za [5];
            logic        zn [5];
            logic [16:0] zs [5];
            logic        zx [5];
            za = '{14'h0003, 14'h0004, 14'h0005, 14'h0006, 14'h0007};
            zn = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            zs = '{17'h00005, 17'h00003, 17'h1FFFE, 17'h1FFF9, 17'h00000};
            zx = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            for (int j = 0; j < 5; j++) send_req(za[j], zn[j]);
            i_valid = 1'b0;
            for (int j = 0; j < 5; j++) begin
                expect_next("zc_sample", zs[j]);
                chk("zc_flag", 32'(last_obs[17]), 32'(zx[j]));
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
